// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmitter and receiver.
//   - FSM state encoding (3-bit): IDLE, START, DATA, PARITY, STOP
//   - parity mode codes carried on parity_mode: PAR_NONE, PAR_EVEN, PAR_ODD
//     (2'b11 is also treated as "no parity")
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // True when the mode asks for a parity bit on the line.
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// uart_tx_hold: one-entry holding register in front of the UART TX FSM.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   i_valid        producer request (tx_start)
//   o_ready        entry free; a word is accepted when i_valid && o_ready
//   i_data/i_par   word and parity mode captured on acceptance
//   i_take         FSM consumes the held word this edge
//   o_data/o_par   held word and parity mode
//   o_valid        entry occupied
module uart_tx_hold
    import uart_pkg::*;
#(
    parameter int DBIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [DBIT-1:0] i_data,
    input  logic [1:0]      i_par,
    input  logic            i_take,
    output logic [DBIT-1:0] o_data,
    output logic [1:0]      o_par,
    output logic            o_valid
);

    logic            r_valid;
    logic [DBIT-1:0] r_data;
    logic [1:0]      r_par;
    logic            w_load;

    assign w_load  = i_valid && !r_valid;
    assign o_ready = !r_valid;
    assign o_data  = r_data;
    assign o_par   = r_par;
    assign o_valid = r_valid;

    // A load wins over a take on the same edge so the new word stays held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_par   <= PAR_NONE;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_par   <= i_par;
        end else if (i_take) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with a one-entry holding buffer.
// Frame: start(0), DBIT data bits LSB first, optional parity, stop(1) for STOP_TICKS.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   s_tick         oversampling strobe (OVERSAMPLE per bit)
//   tx_start       valid; word accepted when tx_start && tx_ready
//   tx_ready       holding buffer free
//   data_in        word to send (sampled on acceptance)
//   parity_mode    00 none, 01 even, 10 odd, 11 none (sampled on acceptance)
//   tx_done_tick   one-clk pulse after the last stop tick
//   tx_busy        FSM not idle
//   tx             registered serial line, idle high
// Build option: define UART_TX_PARITY_EN to build the PARITY state; when it is
// undefined parity_mode is ignored and every frame has no parity bit.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_TICKS = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    output logic            tx_ready,
    input  logic [DBIT-1:0] data_in,
    input  logic [1:0]      parity_mode,
    output logic            tx_done_tick,
    output logic            tx_busy,
    output logic            tx
);

    localparam int SW = $clog2(2 * OVERSAMPLE);
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(STOP_TICKS - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    logic [2:0]      r_state;
    logic [SW-1:0]   r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_b;
    logic            r_tx;
    logic            r_done;

    logic            w_hold_valid;
    logic [DBIT-1:0] w_hold_data;
    logic [1:0]      w_hold_par;
    logic            w_take;
    logic            w_bit_end;
    logic            w_stop_end;
    logic [2:0]      w_after_data;
    logic            w_after_data_tx;

    uart_tx_hold #(.DBIT(DBIT)) u_hold (
        .clk     (clk),
        .reset   (reset),
        .i_valid (tx_start),
        .o_ready (tx_ready),
        .i_data  (data_in),
        .i_par   (parity_mode),
        .i_take  (w_take),
        .o_data  (w_hold_data),
        .o_par   (w_hold_par),
        .o_valid (w_hold_valid)
    );

    assign w_bit_end  = s_tick && (r_s == S_BIT_LAST);
    assign w_stop_end = s_tick && (r_s == S_STOP_LAST);
    // The FSM takes a word from idle, or straight out of the final stop tick.
    assign w_take = w_hold_valid && ((r_state == IDLE) || ((r_state == STOP) && w_stop_end));

`ifdef UART_TX_PARITY_EN
    logic r_par_en;
    logic r_par_bit;

    // Parity is fixed at take-over so the shifting b_reg does not disturb it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_take) begin
            r_par_en  <= par_enabled(w_hold_par);
            r_par_bit <= (^w_hold_data) ^ (w_hold_par == PAR_ODD);
        end
    end

    assign w_after_data    = r_par_en ? PARITY : STOP;
    assign w_after_data_tx = r_par_en ? r_par_bit : 1'b1;
`else
    logic w_unused_par;
    assign w_unused_par    = ^w_hold_par;
    assign w_after_data    = STOP;
    assign w_after_data_tx = 1'b1;
`endif

    // r_tx always takes the level of the state being entered, so every bit
    // starts on the edge of the transition into it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_take) begin
                        r_b     <= w_hold_data;
                        r_s     <= '0;
                        r_n     <= '0;
                        r_state <= START;
                        r_tx    <= 1'b0;
                    end
                end
                START: if (s_tick) begin
                    if (w_bit_end) begin
                        r_s     <= '0;
                        r_state <= DATA;
                        r_tx    <= r_b[0];
                    end else begin
                        r_s <= r_s + 1'b1;
                    end
                end
                DATA: if (s_tick) begin
                    if (w_bit_end) begin
                        r_s <= '0;
                        r_b <= r_b >> 1;
                        if (r_n == N_LAST) begin
                            r_state <= w_after_data;
                            r_tx    <= w_after_data_tx;
                        end else begin
                            // n_reg stops at DBIT-1 so it never wraps.
                            r_n  <= r_n + 1'b1;
                            r_tx <= r_b[1];
                        end
                    end else begin
                        r_s <= r_s + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (s_tick) begin
                    if (w_bit_end) begin
                        r_s     <= '0;
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_s <= r_s + 1'b1;
                    end
                end
`endif
                STOP: if (s_tick) begin
                    if (w_stop_end) begin
                        r_s    <= '0;
                        r_done <= 1'b1;
                        if (w_take) begin
                            r_b     <= w_hold_data;
                            r_n     <= '0;
                            r_state <= START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_s <= r_s + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx           = r_tx;
    assign tx_done_tick = r_done;
    assign tx_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

    localparam int DBIT = 8;
    localparam int OS   = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       hp;
        logic       pb;
        int         len;
        bit         b2b;
    } rec_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] m;
        logic       hp;
        logic       pb;
        int         len;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick = 1'b0;
    logic [7:0] data_in = '0;
    logic [1:0] parity_mode = '0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       ready0, ready1, done0, done1, busy0, busy1, tx0, tx1;

    int   n_chk = 0;
    int   n_pass = 0;
    int   n_push[2];
    int   n_closed[2];
    rec_t q0[$];
    rec_t q1[$];

    uart_tx_frame #(.DBIT(DBIT), .OVERSAMPLE(OS), .STOP_TICKS(16)) u_dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start0), .tx_ready(ready0),
        .data_in(data_in), .parity_mode(parity_mode), .tx_done_tick(done0),
        .tx_busy(busy0), .tx(tx0)
    );

    uart_tx_frame #(.DBIT(DBIT), .OVERSAMPLE(OS), .STOP_TICKS(24)) u_dut1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start1), .tx_ready(ready1),
        .data_in(data_in), .parity_mode(parity_mode), .tx_done_tick(done1),
        .tx_busy(busy1), .tx(tx1)
    );

    always #5 clk = ~clk;

    // s_tick: one clk wide, every third cycle
    initial begin
        forever begin
            repeat (2) @(posedge clk);
            #1 s_tick = 1'b1;
            @(posedge clk);
            #1 s_tick = 1'b0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Line level expected at frame position p (p = s_ticks consumed since start).
    function automatic logic lvl(input rec_t e, input int p);
        int b;
        b = p / OS;
        if (b == 0) return 1'b0;
        if (b <= DBIT) return e.data[b-1];
        if (e.hp && b == DBIT + 1) return e.pb;
        return 1'b1;
    endfunction

    task automatic monitor(input int id);
        rec_t e;
        bit   inf, closed;
        int   p, bad_p;
        logic tk, txv, dn;
        inf = 0; p = 0; bad_p = -1;
        e = '{data: 8'h00, hp: 1'b0, pb: 1'b0, len: 0, b2b: 1'b0};
        forever begin
            @(posedge clk);
            tk = s_tick;
            #1;
            txv = (id == 0) ? tx0 : tx1;
            dn  = (id == 0) ? done0 : done1;
            closed = 0;
            if (!reset) begin
                if (inf) n_closed[id]++;
                inf = 0;
                continue;
            end
            if (inf) begin
                if (tk) p++;
                if (dn || p >= e.len) begin
                    chk($sformatf("frame_len[%0d]", id), p, e.len);
                    chk($sformatf("done_tick[%0d]", id), {31'b0, dn}, 1);
                    chk($sformatf("frame_bits_first_bad_pos[%0d]", id), bad_p, -1);
                    if (e.b2b) chk("b2b_gap_tx", {31'b0, txv}, 0);
                    n_closed[id]++;
                    inf = 0;
                    closed = 1;
                end else if (txv !== lvl(e, p) && bad_p < 0) begin
                    bad_p = p;
                end
            end else if (dn) begin
                chk($sformatf("spurious_done[%0d]", id), {31'b0, dn}, 0);
            end
            if (!inf && txv === 1'b0) begin
                if (id == 0 && q0.size() > 0) e = q0.pop_front();
                else if (id == 1 && q1.size() > 0) e = q1.pop_front();
                else begin
                    chk($sformatf("unexpected_frame[%0d]", id), {31'b0, txv}, 1);
                    e = '{data: 8'h00, hp: 1'b0, pb: 1'b0, len: 1 << 20, b2b: 1'b0};
                end
                inf = 1; p = 0; bad_p = -1;
            end
            if (closed && dn && inf && p != 0) bad_p = bad_p; // no-op keeps flow explicit
        end
    endtask

    task automatic send(input int id, input logic [7:0] d, input logic [1:0] m,
                        input logic hp, input logic pb, input int len,
                        input bit b2b, input bit push);
        int   n;
        rec_t r;
        n = 0;
        data_in = d;
        parity_mode = m;
        if (id == 0) start0 = 1'b1; else start1 = 1'b1;
        while (((id == 0) ? ready0 : ready1) !== 1'b1 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 3000) chk("accept_timeout", {31'b0, (id == 0) ? ready0 : ready1}, 1);
        @(posedge clk);
        if (push) begin
            r = '{data: d, hp: hp, pb: pb, len: len, b2b: b2b};
            if (id == 0) q0.push_back(r); else q1.push_back(r);
            n_push[id]++;
        end
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        data_in = ~d;          // later changes must not affect the accepted word
        parity_mode = ~m;
        chk("ready_drop", {31'b0, (id == 0) ? ready0 : ready1}, 0);
    endtask

    task automatic drain(input int id);
        int n;
        n = 0;
        while (n_closed[id] != n_push[id] && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        chk($sformatf("drain[%0d]_open_frames", id), n_push[id] - n_closed[id], 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    vec_t tbl[6];

    initial begin
        int nt, nd;
        n_push[0] = 0; n_push[1] = 0; n_closed[0] = 0; n_closed[1] = 0;

        tbl[0] = '{d: 8'h55, m: 2'b00, hp: 1'b0, pb: 1'b0, len: 160};
        tbl[1] = '{d: 8'h07, m: 2'b01, hp: PE, pb: PE, len: PE ? 176 : 160};
        tbl[2] = '{d: 8'h07, m: 2'b10, hp: PE, pb: 1'b0, len: PE ? 176 : 160};
        tbl[3] = '{d: 8'h80, m: 2'b10, hp: PE, pb: 1'b0, len: PE ? 176 : 160};
        tbl[4] = '{d: 8'hC3, m: 2'b01, hp: PE, pb: 1'b0, len: PE ? 176 : 160};
        tbl[5] = '{d: 8'h5A, m: 2'b11, hp: 1'b0, pb: 1'b0, len: 160};

        fork
            monitor(0);
            monitor(1);
        join_none

        // reset state
        #23;
        chk("rst_tx", {31'b0, tx0}, 1);
        chk("rst_ready", {31'b0, ready0}, 1);
        chk("rst_busy", {31'b0, busy0}, 0);
        chk("rst_done", {31'b0, done0}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            send(0, tbl[i].d, tbl[i].m, tbl[i].hp, tbl[i].pb, tbl[i].len, 1'b0, 1'b1);
            drain(0);
        end

        // back-to-back with latency check on the first word
        send(0, 8'hA5, 2'b00, 1'b0, 1'b0, 160, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("lat_tx_low", {31'b0, tx0}, 0);
        chk("lat_ready_back", {31'b0, ready0}, 1);
        chk("lat_busy", {31'b0, busy0}, 1);
        send(0, 8'h3C, 2'b00, 1'b0, 1'b0, 160, 1'b0, 1'b1);
        drain(0);

        // 24-tick stop interval
        send(1, 8'hFF, 2'b00, 1'b0, 1'b0, 9 * OS + 24, 1'b0, 1'b1);
        drain(1);

        // reset during data bit 3 with a word waiting in the holding register
        send(0, 8'h00, 2'b00, 1'b0, 1'b0, 160, 1'b0, 1'b1);
        send(0, 8'h99, 2'b00, 1'b0, 1'b0, 160, 1'b0, 1'b0);
        nt = 0;
        while (nt < 70) begin
            @(posedge clk);
            if (s_tick) nt++;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_tx_high", {31'b0, tx0}, 1);
        chk("abort_ready", {31'b0, ready0}, 1);
        chk("abort_busy", {31'b0, busy0}, 0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done0 !== 1'b0) nd++;
        end
        chk("abort_no_done", nd, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        send(0, 8'h3A, 2'b00, 1'b0, 1'b0, 160, 1'b0, 1'b1);
        drain(0);

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter: next generation of the team's fixed 8N1 serial transmitter. It adds:
- configurable data width, oversampling ratio and stop length
- runtime-selectable parity
- a one-entry holding buffer with a ready/valid handshake, so back-to-back frames go out with no idle gap

It sits between the system's byte source (FIFO or controller) and the serial pin. It shares the external baud-tick generator with the UART receiver.

## Interface
Parameters:
- DBIT, 8: data bits per frame; legal range 5–9.
- OVERSAMPLE, 16: s_tick pulses per bit period; legal range 8–32.
- STOP_TICKS, 16: s_tick pulses in the stop interval. Use OVERSAMPLE for 1 stop bit, 1.5×OVERSAMPLE for 1.5, 2×OVERSAMPLE for 2. Must be ≤ 2×OVERSAMPLE.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset; asserted at 0.
- s_tick  in  1  one-clk-wide oversampling strobe from the baud generator.
- tx_start  in  1  valid: request to transmit data_in.
- tx_ready  out  1  buffer can accept a word. A word is accepted on a rising edge where tx_start && tx_ready.
- data_in  in  DBIT  word to send; sampled on acceptance.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none; sampled on acceptance.
- tx_done_tick  out  1  one-clk pulse at the end of each frame's stop interval.
- tx_busy  out  1  high while the FSM is not in IDLE.
- tx  out  1  serial line; registered output; idle level 1.

## Operation
- Holding register (hold_data, hold_par, hold_valid):
  - Loaded on acceptance.
  - Cleared when the FSM takes the word.
  - tx_ready = !hold_valid.
- If acceptance and take-over happen on the same edge, the new word is loaded and hold_valid stays 1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx = 1.
  - If hold_valid: copy the word into the shift register b_reg, copy its parity mode, clear s_reg and n_reg, then go to START.
- START: tx = 0. Hold for OVERSAMPLE s_ticks, then go to DATA.
- DATA:
  - tx = b_reg[0], so data goes out LSB first.
  - After every OVERSAMPLE s_ticks, shift b_reg right and increment n_reg.
  - After bit DBIT−1, go to PARITY if the latched mode is even or odd, otherwise go to STOP.
- PARITY:
  - tx = XOR of all data bits for even parity; its inverse for odd.
  - The parity bit is computed at take-over and held in a register.
  - Hold for OVERSAMPLE s_ticks, then go to STOP.
- STOP:
  - tx = 1. Hold for STOP_TICKS s_ticks.
  - At the end, pulse tx_done_tick.
  - If hold_valid, take the word and go directly to START. Otherwise go to IDLE.
- Widths:
  - s_reg is $clog2(2×OVERSAMPLE) bits.
  - n_reg is $clog2(DBIT) bits.
  - Counters compare against (limit − 1) and never wrap in normal operation.
- s_tick outside START/DATA/PARITY/STOP is ignored.

## Timing
- Reset values (asserted, asynchronous):
  - tx = 1, tx_ready = 1, tx_busy = 0, tx_done_tick = 0.
  - State IDLE, hold_valid = 0, all counters and b_reg = 0.
- Reset mid-frame: the frame is aborted immediately, tx returns to 1 asynchronously, no tx_done_tick is produced, and any held word is discarded.
- Latency from an idle line:
  - Acceptance at edge k.
  - At edge k+1 the FSM enters START, tx falls to 0 and tx_ready returns to 1.
- tx is loaded from the next-state bit value on the same edge as each transition. Each START, DATA and PARITY bit therefore lasts exactly OVERSAMPLE s_ticks, and STOP lasts exactly STOP_TICKS s_ticks.
- Frame length: (1 + DBIT + P) × OVERSAMPLE + STOP_TICKS s_ticks, where P = 1 with parity and 0 without.
- tx_done_tick is registered: high for the clk cycle after the edge that consumes the last stop tick.
- Back-to-back frames: the start bit of the next frame begins on the edge that ends STOP, with zero idle ticks between frames.
- Data_in and parity_mode changes while not accepting have no effect.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state and parity register are built, and parity_mode behaves as above.
- UART_TX_PARITY_EN undefined:
  - PARITY state and parity logic are removed.
  - parity_mode remains a port but is ignored; every frame is sent with no parity.

## Structure
- Shared package uart_pkg holds:
  - the state encoding localparams (IDLE..STOP, 3-bit)
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD
- The same package is reused by the successor receiver.
- One sub-module: uart_tx_hold, the one-entry holding register plus ready/valid logic. Everything else lives in uart_tx_frame.

## Test plan
All scenarios use DBIT=8 and OVERSAMPLE=16 unless stated.
- STOP_TICKS=16, send 0x55 with parity_mode=00:
  - tx sequence per 16 ticks is 0,1,0,1,0,1,0,1,0,1.
  - Frame is 160 ticks; exactly one tx_done_tick.
- Send 0x07 with even parity, then 0x07 with odd parity (macro defined): parity bit is 1, then 0; each frame is 176 ticks.
- Back-to-back: hold tx_start high with 0xA5 then 0x3C.
  - Second start bit begins on the same edge the first stop interval ends.
  - tx_ready drops on each acceptance.
- STOP_TICKS=24, send 0xFF: stop level 1 holds for exactly 24 ticks before tx_done_tick.
- Reset: assert reset low during data bit 3 of 0x00.
  - tx goes to 1 immediately and tx_ready = 1.
  - No tx_done_tick.
  - After release, the next accepted word transmits correctly.
- Macro undefined, parity_mode=01, send 0x07: no parity bit is sent; frame is 160 ticks.
